// File: rtl/led_code_encoder.sv
// led_code_encoder
//
// Purpose:
//   Turns the four front-panel colour buttons into the 2-bit LED colour code
//   used by the LED decode logic. Every raw button is synchronised, debounced
//   and edge-detected. A press is delivered as one code word through a
//   one-deep output register. A sticky flag records any press that was lost.
//   The block also drives the shared LED enable, which a separate clear
//   button switches off.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   btnIn      in   4  raw colour buttons, active-high, asynchronous
//                      [0]=RED [1]=GREEN [2]=BLUE [3]=YELLOW
//   btnClear   in   1  raw clear button, active-high, asynchronous
//   dataOut    out  2  colour code: RED=00 GREEN=01 BLUE=10 YELLOW=11
//   dataValid  out  1  dataOut holds a code that has not been delivered
//   dataReady  in   1  consumer takes the code on this edge
//   ledOn      out  1  LED enable for the decoder
//   overrun    out  1  sticky, a press was lost; cleared by clear or reset
//
// Handshake (dataValid/dataReady):
//   A code moves to the consumer only on a rising edge where dataValid and
//   dataReady are both 1. dataOut does not change while dataValid is 1,
//   except on a transfer edge, where a new code may replace the one that
//   just left. dataReady has no effect while dataValid is 0. The register
//   is one deep. A new press that arrives while a code is waiting and
//   dataReady is 0 is dropped, and overrun is set.

module led_code_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btnIn,
  input  logic       btnClear,
  output logic [1:0] dataOut,
  output logic       dataValid,
  input  logic       dataReady,
  output logic       ledOn,
  output logic       overrun
);

  localparam int N_IN = 5;
  localparam int CLR_IDX = 4;
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Synchronisers: bit 4 is the clear button, bits 3:0 are the colours
  // ---------------------------------------------------------------------
  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;

  assign raw = {btnClear, btnIn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce
  // A counter runs only while the synchronised input differs from the
  // stable state. When the count is already DEBOUNCE_CYCLES-1 and the input
  // still differs, the stable state flips. The input therefore has to
  // differ on DEBOUNCE_CYCLES consecutive samples. The counter clears when
  // the state flips, so it never wraps.
  // ---------------------------------------------------------------------
  logic [N_IN-1:0]     stable;
  logic [N_IN-1:0]     stable_d;
  logic [DB_CNT_W-1:0] db_cnt [N_IN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < N_IN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed copy of the stable states, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  // ---------------------------------------------------------------------
  // Press events
  // Each event is a one-cycle pulse on a 0->1 change of a stable state.
  // A release (1->0) produces no event.
  // ---------------------------------------------------------------------
  logic [N_IN-1:0] press;
  logic            clear_ev;
  logic [3:0]      colour_ev;
  logic            any_colour;
  logic            multi_colour;
  logic [1:0]      win_code;

  assign press        = stable & ~stable_d;
  assign clear_ev     = press[CLR_IDX];
  assign colour_ev    = press[3:0];
  assign any_colour   = |colour_ev;
  // True when more than one colour event is active in the same cycle.
  // Only the lowest index is kept; every other event counts as a loss.
  assign multi_colour = (colour_ev & (colour_ev - 4'd1)) != 4'd0;

  // The lowest set index wins. The loop runs from the top down, so the
  // lowest index is the last one written.
  always_comb begin
    win_code = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (colour_ev[i]) begin
        win_code = 2'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register and flags
  // ---------------------------------------------------------------------
  logic [1:0] data_out_n;
  logic       data_valid_n;
  logic       led_on_n;
  logic       overrun_n;
  logic       transfer;

  assign transfer = dataValid & dataReady;

  always_comb begin
    data_out_n   = dataOut;
    data_valid_n = dataValid;
    led_on_n     = ledOn;
    overrun_n    = overrun;

    // A transfer empties the register unless a new code replaces it below.
    if (transfer) begin
      data_valid_n = 1'b0;
    end

    if (clear_ev) begin
      // A clear takes priority over every colour event in the same cycle.
      // The clear itself leaves the code register alone.
      led_on_n  = 1'b0;
      overrun_n = 1'b0;
    end else if (any_colour) begin
      if (!dataValid || dataReady) begin
        data_out_n   = win_code;
        data_valid_n = 1'b1;
        led_on_n     = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
      if (multi_colour) begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut   <= 2'b00;
      dataValid <= 1'b0;
      ledOn     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dataOut   <= data_out_n;
      dataValid <= data_valid_n;
      ledOn     <= led_on_n;
      overrun   <= overrun_n;
    end
  end

endmodule
